// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core: steps each instruction through
// fetch, decode, execute, memory and writeback, and decodes the datapath
// controls (ALU op class, operand selects, write enables, memory handshake)
// from the current state.
module multicycle_controller #(
    parameter bit ENABLE_FENCE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] alu_op,
    output logic [2:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       addr_src,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_EXEC_LUI, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WR, S_MEM_WB, S_ALU_WB, S_BRANCH, S_JALR_ADD,
        S_JALR_MASK, S_JUMP, S_TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_BRCMP = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;

    localparam logic [2:0] A_PC     = 3'b000;
    localparam logic [2:0] A_OLDPC  = 3'b001;
    localparam logic [2:0] A_RS1    = 3'b010;
    localparam logic [2:0] A_ALUOUT = 3'b011;
    localparam logic [2:0] A_ZERO   = 3'b100;

    localparam logic [1:0] B_RS2   = 2'b00;
    localparam logic [1:0] B_IMM   = 2'b01;
    localparam logic [1:0] B_FOUR  = 2'b10;
    localparam logic [1:0] B_MASK  = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] w_alu_op;
    logic [2:0] w_src_a;
    logic [1:0] w_src_b;
    logic [1:0] w_result_src;
    logic       w_addr_src;
    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_reg_write;
    logic       w_instr_done;
    logic       w_illegal;

    // State register; reset returns the sequencer to FETCH.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next_state;
    end

    // Next-state and Moore output decode, with per-state deviations from defaults.
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_alu_op     = ALU_ADD;
        w_src_a      = A_PC;
        w_src_b      = B_RS2;
        w_result_src = RES_ALUOUT;
        w_addr_src   = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_instr_done = 1'b0;
        w_illegal    = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_src_b      = B_FOUR;
                    w_result_src = RES_ALU;
                    w_pc_write   = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute OldPC + imm: branch/JAL/AUIPC target lands in ALUOut.
                w_src_a = A_OLDPC;
                w_src_b = B_IMM;
                case (opcode)
                    OP_R:               w_next_state = S_EXEC_R;
                    OP_IMM:             w_next_state = S_EXEC_I;
                    OP_LOAD, OP_STORE:  w_next_state = S_MEM_ADDR;
                    OP_BRANCH:          w_next_state = S_BRANCH;
                    OP_JAL:             w_next_state = S_JUMP;
                    OP_JALR:            w_next_state = S_JALR_ADD;
                    OP_LUI:             w_next_state = S_EXEC_LUI;
                    OP_AUIPC:           w_next_state = S_ALU_WB;
                    OP_FENCE: begin
                        if (ENABLE_FENCE) begin
                            w_instr_done = 1'b1;
                            w_next_state = S_FETCH;
                        end else begin
                            w_next_state = S_TRAP;
                        end
                    end
                    default:            w_next_state = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                w_src_a = A_RS1;
                w_src_b = B_RS2;
                w_alu_op = ALU_FUNCT;
                w_next_state = S_ALU_WB;
            end
            S_EXEC_I: begin
                w_src_a = A_RS1;
                w_src_b = B_IMM;
                w_alu_op = ALU_FUNCT;
                w_next_state = S_ALU_WB;
            end
            S_EXEC_LUI: begin
                w_src_a = A_ZERO;
                w_src_b = B_IMM;
                w_next_state = S_ALU_WB;
            end
            S_MEM_ADDR: begin
                w_src_a = A_RS1;
                w_src_b = B_IMM;
                w_next_state = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_mem_req  = 1'b1;
                w_addr_src = 1'b1;
                if (mem_ready) w_next_state = S_MEM_WB;
            end
            S_MEM_WR: begin
                w_mem_req  = 1'b1;
                w_mem_we   = 1'b1;
                w_addr_src = 1'b1;
                if (mem_ready) begin
                    w_instr_done = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_MEM_WB: begin
                w_result_src = RES_DATA;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_ALU_WB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                w_src_a  = A_RS1;
                w_src_b  = B_RS2;
                w_alu_op = ALU_BRCMP;
                // funct3 010/011 are not branch encodings.
                if (funct3[2:1] == 2'b01) begin
                    w_next_state = S_TRAP;
                end else begin
                    w_pc_write   = zero ^ (funct3[0] ^ funct3[2]);
                    w_instr_done = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_JALR_ADD: begin
                w_src_a = A_RS1;
                w_src_b = B_IMM;
                w_next_state = S_JALR_MASK;
            end
            S_JALR_MASK: begin
                // Clear bit 0 of the jump target.
                w_src_a  = A_ALUOUT;
                w_src_b  = B_MASK;
                w_alu_op = ALU_AND;
                w_next_state = S_JUMP;
            end
            S_JUMP: begin
                // Target leaves ALUOut into PC while OldPC + 4 forms the link.
                w_pc_write = 1'b1;
                w_src_a    = A_OLDPC;
                w_src_b    = B_FOUR;
                w_next_state = S_ALU_WB;
            end
            S_TRAP: begin
                w_illegal = 1'b1;
            end
            default: w_next_state = S_TRAP;
        endcase
    end

    // NOTE: outputs are gated by rst_n so an asserted reset drops every
    // control (including an outstanding mem_req) without waiting for a clock.
    assign alu_op     = rst_n ? w_alu_op     : 3'b000;
    assign alu_src_a  = rst_n ? w_src_a      : 3'b000;
    assign alu_src_b  = rst_n ? w_src_b      : 2'b00;
    assign result_src = rst_n ? w_result_src : 2'b00;
    assign addr_src   = rst_n & w_addr_src;
    assign mem_req    = rst_n & w_mem_req;
    assign mem_we     = rst_n & w_mem_we;
    assign ir_write   = rst_n & w_ir_write;
    assign pc_write   = rst_n & w_pc_write;
    assign reg_write  = rst_n & w_reg_write;
    assign instr_done = rst_n & w_instr_done;
    assign illegal    = rst_n & w_illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus
// randomized instruction streams scored against a per-instruction model.
module tb_multicycle_controller;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic [2:0] alu_op, alu_src_a;
    logic [1:0] alu_src_b, result_src;
    logic       addr_src, mem_req, mem_we, ir_write, pc_write, reg_write, instr_done, illegal;

    logic [2:0] f_alu_op, f_alu_src_a;
    logic [1:0] f_alu_src_b, f_result_src;
    logic       f_addr_src, f_mem_req, f_mem_we, f_ir_write, f_pc_write, f_reg_write;
    logic       f_instr_done, f_illegal;

    multicycle_controller #(.ENABLE_FENCE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .addr_src(addr_src),
        .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .instr_done(instr_done), .illegal(illegal)
    );

    multicycle_controller #(.ENABLE_FENCE(1'b0)) dut_nofence (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .alu_op(f_alu_op), .alu_src_a(f_alu_src_a),
        .alu_src_b(f_alu_src_b), .result_src(f_result_src), .addr_src(f_addr_src),
        .mem_req(f_mem_req), .mem_we(f_mem_we), .ir_write(f_ir_write), .pc_write(f_pc_write),
        .reg_write(f_reg_write), .instr_done(f_instr_done), .illegal(f_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [2:0] src_a;
        logic [1:0] src_b;
        logic [1:0] res_src;
        logic       addr_src;
        logic       mem_req;
        logic       mem_we;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       instr_done;
        logic       illegal;
    } smp_t;

    typedef struct {
        int cycles;
        int reg_writes;
        int pc_writes;
        int dones;
        int data_cycles;
        int we_cycles;
        bit trap;
    } run_t;

    smp_t trace [0:63];
    int   n_cyc;
    int   f_dones;
    int   n_checks = 0;
    int   n_pass = 0;

    // Reference: what one instruction should do, from the ISA-level rules.
    function automatic run_t model(input logic [6:0] op, input logic [2:0] f3,
                                   input logic z, input int fw, input int mw);
        run_t e;
        bit taken;
        e = '{cycles: 0, reg_writes: 0, pc_writes: 1, dones: 1,
              data_cycles: 0, we_cycles: 0, trap: 1'b0};
        case (f3)
            3'b000, 3'b101, 3'b111: taken = z;
            default:                taken = !z;
        endcase
        case (op)
            OP_R, OP_IMM, OP_LUI: begin e.cycles = 4; e.reg_writes = 1; end
            OP_AUIPC:             begin e.cycles = 3; e.reg_writes = 1; end
            OP_LOAD: begin
                e.cycles = 5 + mw; e.reg_writes = 1; e.data_cycles = mw + 1;
            end
            OP_STORE: begin
                e.cycles = 4 + mw; e.data_cycles = mw + 1; e.we_cycles = mw + 1;
            end
            OP_BRANCH: begin
                if (f3 == 3'b010 || f3 == 3'b011) begin
                    e.cycles = 4; e.trap = 1'b1; e.dones = 0;
                end else begin
                    e.cycles = 3; e.pc_writes = 1 + int'(taken);
                end
            end
            OP_JAL:   begin e.cycles = 4; e.reg_writes = 1; e.pc_writes = 2; end
            OP_JALR:  begin e.cycles = 6; e.reg_writes = 1; e.pc_writes = 2; end
            OP_FENCE: e.cycles = 2;
            default:  begin e.cycles = 3; e.trap = 1'b1; e.dones = 0; end
        endcase
        e.cycles += fw;
        return e;
    endfunction

    // Execute one instruction from FETCH, acting as a memory with the given
    // wait counts, recording one sample per cycle until retire or trap.
    // Entry and exit are 1 time unit after a rising edge.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input int fw, input int mw);
        int  fcnt, dcnt;
        bit  fin;
        fcnt = fw; dcnt = mw; fin = 1'b0; n_cyc = 0; f_dones = 0;
        opcode = op; funct3 = f3; zero = z;
        for (int c = 0; c < 64 && !fin; c++) begin
            mem_ready = 1'b0;
            if (mem_req && !addr_src) begin
                if (fcnt == 0) mem_ready = 1'b1; else fcnt--;
            end else if (mem_req && addr_src) begin
                if (dcnt == 0) mem_ready = 1'b1; else dcnt--;
            end
            @(negedge clk);
            trace[c] = '{alu_op, alu_src_a, alu_src_b, result_src, addr_src, mem_req,
                         mem_we, ir_write, pc_write, reg_write, instr_done, illegal};
            if (f_instr_done) f_dones++;
            n_cyc = c + 1;
            if (instr_done || illegal) fin = 1'b1;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
    endtask

    function automatic run_t summarize();
        run_t o;
        o = '{cycles: n_cyc, reg_writes: 0, pc_writes: 0, dones: 0,
              data_cycles: 0, we_cycles: 0, trap: 1'b0};
        for (int c = 0; c < n_cyc; c++) begin
            o.reg_writes  += int'(trace[c].reg_write);
            o.pc_writes   += int'(trace[c].pc_write);
            o.dones       += int'(trace[c].instr_done);
            o.data_cycles += int'(trace[c].mem_req && trace[c].addr_src);
            o.we_cycles   += int'(trace[c].mem_we);
            if (trace[c].illegal) o.trap = 1'b1;
        end
        return o;
    endfunction

    task automatic do_reset();
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [19:0] outs;
        bit bad;
        rst_n = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk); #1;
        outs = {alu_op, alu_src_a, alu_src_b, result_src, addr_src, mem_req, mem_we,
                ir_write, pc_write, reg_write, instr_done, illegal, f_mem_req, f_illegal};
        n_checks++;
        if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs); else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        // Mid-FETCH with mem_ready low: pull reset away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0) $display("FAIL reset_async_drop: mem_req got %b want 0", mem_req);
        else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        #1;
        n_checks++;
        if ({mem_req, addr_src, illegal} !== 3'b100)
            $display("FAIL reset_first_req: req/addr_src/illegal got %b want 100",
                     {mem_req, addr_src, illegal});
        else n_pass++;
        bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if ({mem_req, addr_src, ir_write, pc_write, reg_write, instr_done} !== 6'b100000)
                bad = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad) $display("FAIL reset_no_write_before_ready: got a write or lost request");
        else n_pass++;
    endtask

    task automatic test_add();
        logic [3:0] rw, dn;
        run_instr(OP_R, 3'b000, 1'b0, 0, 0);
        n_checks++;
        if (n_cyc !== 4) $display("FAIL add_cycles: got %0d want 4", n_cyc); else n_pass++;
        n_checks++;
        if ({trace[0].ir_write, trace[0].pc_write, trace[0].src_a, trace[0].src_b, trace[0].res_src}
            !== {1'b1, 1'b1, 3'b000, 2'b10, 2'b10})
            $display("FAIL add_fetch_ctrl: got %b", {trace[0].ir_write, trace[0].pc_write,
                     trace[0].src_a, trace[0].src_b, trace[0].res_src});
        else n_pass++;
        n_checks++;
        if ({trace[1].alu_op, trace[1].src_a, trace[1].src_b} !== {3'b000, 3'b001, 2'b01})
            $display("FAIL add_decode_ctrl: got %b want 00000101",
                     {trace[1].alu_op, trace[1].src_a, trace[1].src_b});
        else n_pass++;
        n_checks++;
        if ({trace[2].alu_op, trace[2].src_a, trace[2].src_b} !== {3'b010, 3'b010, 2'b00})
            $display("FAIL add_exec_ctrl: got %b want 01001000",
                     {trace[2].alu_op, trace[2].src_a, trace[2].src_b});
        else n_pass++;
        rw = {trace[3].reg_write, trace[2].reg_write, trace[1].reg_write, trace[0].reg_write};
        dn = {trace[3].instr_done, trace[2].instr_done, trace[1].instr_done, trace[0].instr_done};
        n_checks++;
        if ({rw, dn} !== 8'b1000_1000)
            $display("FAIL add_wb_done: reg_write %b done %b want 1000 1000", rw, dn);
        else n_pass++;
    endtask

    task automatic test_load_wait();
        logic [7:0] dreq;
        run_instr(OP_LOAD, 3'b010, 1'b0, 0, 3);
        n_checks++;
        if (n_cyc !== 8) $display("FAIL load_cycles: got %0d want 8", n_cyc); else n_pass++;
        dreq = '0;
        for (int c = 0; c < 8; c++) dreq[c] = trace[c].mem_req && trace[c].addr_src;
        n_checks++;
        if (dreq !== 8'b0111_1000) $display("FAIL load_data_req: got %b want 01111000", dreq);
        else n_pass++;
        n_checks++;
        if ({trace[7].res_src, trace[7].reg_write, trace[7].instr_done, trace[7].mem_req}
            !== {2'b01, 1'b1, 1'b1, 1'b0})
            $display("FAIL load_mem_wb: got %b want 01110", {trace[7].res_src,
                     trace[7].reg_write, trace[7].instr_done, trace[7].mem_req});
        else n_pass++;
    endtask

    task automatic check_trap_sticky(input string name);
        bit bad;
        bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if ({illegal, mem_req, instr_done, pc_write, reg_write, ir_write} !== 6'b100000)
                bad = 1'b1;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        n_checks++;
        if (bad) $display("FAIL %s_sticky: trap state not held or controls active", name);
        else n_pass++;
    endtask

    task automatic test_branch();
        logic [2:0] f3s   [5] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b111};
        logic       zs    [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       takes [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            run_instr(OP_BRANCH, f3s[i], zs[i], 0, 0);
            n_checks++;
            if ({n_cyc == 3, trace[2].pc_write, trace[2].alu_op, trace[2].instr_done}
                !== {1'b1, takes[i], 3'b011, 1'b1})
                $display("FAIL branch_f3_%b_z%b: cycles %0d pc_write %b alu_op %b done %b want pc_write %b",
                         f3s[i], zs[i], n_cyc, trace[2].pc_write, trace[2].alu_op,
                         trace[2].instr_done, takes[i]);
            else n_pass++;
        end
        run_instr(OP_BRANCH, 3'b010, 1'b1, 0, 0);
        n_checks++;
        if ({n_cyc == 4, trace[3].illegal, trace[2].pc_write, trace[2].instr_done} !== 4'b1100)
            $display("FAIL branch_bad_funct3: cycles %0d illegal %b pc_write %b done %b",
                     n_cyc, trace[3].illegal, trace[2].pc_write, trace[2].instr_done);
        else n_pass++;
        check_trap_sticky("branch_trap");
        do_reset();
    endtask

    task automatic test_jalr();
        run_instr(OP_JALR, 3'b000, 1'b0, 0, 0);
        n_checks++;
        if (n_cyc !== 6) $display("FAIL jalr_cycles: got %0d want 6", n_cyc); else n_pass++;
        n_checks++;
        if ({trace[3].alu_op, trace[3].src_a, trace[3].src_b} !== {3'b100, 3'b011, 2'b11})
            $display("FAIL jalr_mask: got %b want 10001111",
                     {trace[3].alu_op, trace[3].src_a, trace[3].src_b});
        else n_pass++;
        n_checks++;
        if ({trace[4].pc_write, trace[4].res_src, trace[4].src_a, trace[4].src_b}
            !== {1'b1, 2'b00, 3'b001, 2'b10})
            $display("FAIL jalr_jump: got %b want 10000110", {trace[4].pc_write,
                     trace[4].res_src, trace[4].src_a, trace[4].src_b});
        else n_pass++;
        n_checks++;
        if ({trace[5].reg_write, trace[5].instr_done, trace[4].reg_write} !== 3'b110)
            $display("FAIL jalr_wb: got %b want 110",
                     {trace[5].reg_write, trace[5].instr_done, trace[4].reg_write});
        else n_pass++;
    endtask

    task automatic test_trap();
        run_instr(OP_SYSTEM, 3'b000, 1'b0, 1, 0);
        n_checks++;
        if ({n_cyc == 4, trace[3].illegal, trace[2].illegal, trace[3].instr_done} !== 4'b1100)
            $display("FAIL trap_entry: cycles %0d illegal %b done %b", n_cyc,
                     trace[3].illegal, trace[3].instr_done);
        else n_pass++;
        check_trap_sticky("system_trap");
        do_reset();
    endtask

    task automatic test_fence();
        run_instr(OP_FENCE, 3'b000, 1'b0, 0, 0);
        n_checks++;
        if ({n_cyc == 2, trace[1].instr_done, trace[1].illegal} !== 3'b110)
            $display("FAIL fence_retire: cycles %0d done %b illegal %b",
                     n_cyc, trace[1].instr_done, trace[1].illegal);
        else n_pass++;
        n_checks++;
        if ({f_illegal, f_mem_req, f_dones == 0} !== 3'b101)
            $display("FAIL fence_disabled_trap: illegal %b mem_req %b dones %0d want 1 0 0",
                     f_illegal, f_mem_req, f_dones);
        else n_pass++;
        run_instr(OP_R, 3'b000, 1'b0, 0, 0);
        n_checks++;
        if (n_cyc !== 4) $display("FAIL fence_then_add: cycles got %0d want 4", n_cyc);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_random();
        logic [6:0] ops [10] = '{OP_R, OP_IMM, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE,
                                 OP_BRANCH, OP_JAL, OP_JALR, OP_FENCE};
        logic [2:0] bf3 [6]  = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        logic [6:0] op;
        logic [2:0] f3;
        logic       z;
        int         fw, mw;
        run_t       e, o;
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 9)];
            f3 = (op == OP_BRANCH) ? bf3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            z  = 1'($urandom_range(0, 1));
            fw = $urandom_range(0, 3);
            mw = $urandom_range(0, 3);
            e  = model(op, f3, z, fw, mw);
            run_instr(op, f3, z, fw, mw);
            o  = summarize();
            n_checks++;
            if (o.cycles !== e.cycles || o.reg_writes !== e.reg_writes || o.pc_writes !== e.pc_writes ||
                o.dones !== e.dones || o.data_cycles !== e.data_cycles ||
                o.we_cycles !== e.we_cycles || o.trap !== e.trap)
                $display("FAIL random_%0d op %b f3 %b z %b fw %0d mw %0d: got cyc %0d rw %0d pcw %0d done %0d dreq %0d we %0d trap %b want cyc %0d rw %0d pcw %0d done %0d dreq %0d we %0d trap %b",
                         i, op, f3, z, fw, mw, o.cycles, o.reg_writes, o.pc_writes, o.dones,
                         o.data_cycles, o.we_cycles, o.trap, e.cycles, e.reg_writes,
                         e.pc_writes, e.dones, e.data_cycles, e.we_cycles, e.trap);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_wait();
        test_branch();
        test_jalr();
        test_fence();
        test_trap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style sequencing FSM for the multicycle RV32I core. It walks each instruction through fetch, decode, execute, memory and writeback. It drives the 3-bit `alu_op` class consumed by the ALU decoder, plus the operand-select, register/PC/IR write-enable and memory-handshake controls of the shared single-ALU datapath.

## Interface
- `ENABLE_FENCE`, default 1: 1 = FENCE (0001111) retires as a no-op; 0 = FENCE traps as illegal.

- `clk`  in  1  single core clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  `IR[6:0]`, valid from DECODE onward.
- `funct3`  in  3  `IR[14:12]`, used for branch resolution.
- `zero`  in  1  ALU result == 0, combinational from this cycle's ALU operation.
- `mem_ready`  in  1  memory completes the current request this cycle (read data valid / write accepted).
- `alu_op`  out  3  000 add, 001 sub, 010 funct-decoded, 011 branch compare, 100 and.
- `alu_src_a`  out  3  000 PC, 001 OldPC, 010 reg A (rs1), 011 ALUOut, 100 zero.
- `alu_src_b`  out  2  00 reg B (rs2), 01 imm, 10 constant 4, 11 constant 0xFFFF_FFFE.
- `result_src`  out  2  00 ALUOut, 01 data register, 10 ALU result (direct).
- `addr_src`  out  1  memory address: 0 PC, 1 result bus.
- `mem_req`  out  1  memory request, held until `mem_ready`.
- `mem_we`  out  1  write qualifier for `mem_req`.
- `ir_write`  out  1  load IR and OldPC; data register loads on any accepted read.
- `pc_write`  out  1  PC <= result bus.
- `reg_write`  out  1  rd <= result bus.
- `instr_done`  out  1  one-cycle pulse on the last cycle of every retired instruction.
- `illegal`  out  1  sticky trap flag.

## Operation
- **Defaults per state:** all enables 0, `alu_op` 000, sources 000/00/00, `addr_src` 0. Each state below lists only deviations. ALUOut captures the ALU result every cycle.
- **FETCH:** `mem_req`=1.
  - On `mem_ready`: `ir_write`=1, a=PC, b=4, add, `result_src`=10, `pc_write`=1 -> DECODE.
  - Otherwise stay in FETCH with no writes.
- **DECODE:** a=OldPC, b=imm, add (branch/JAL/AUIPC target into ALUOut). Dispatch on opcode:
  - 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011/0100011 -> MEM_ADDR; 1100011 -> BRANCH.
  - 1101111 -> JUMP; 1100111 -> JALR_ADD; 0110111 -> EXEC_LUI; 0010111 -> ALU_WB.
  - 0001111 -> FETCH with `instr_done` if `ENABLE_FENCE`, else TRAP.
  - Anything else -> TRAP.
- **EXEC_R:** a=rs1, b=rs2, op 010 -> ALU_WB.
- **EXEC_I:** a=rs1, b=imm, op 010 -> ALU_WB.
- **EXEC_LUI:** a=zero, b=imm, add -> ALU_WB.
- **MEM_ADDR:** a=rs1, b=imm, add -> MEM_RD on load, MEM_WR on store.
- **MEM_RD:** `mem_req`=1, `addr_src`=1, `result_src`=00. On `mem_ready` -> MEM_WB.
- **MEM_WR:** `mem_req`=1, `mem_we`=1, `addr_src`=1. On `mem_ready` -> FETCH with `instr_done`.
- **MEM_WB:** `result_src`=01, `reg_write`=1, `instr_done` -> FETCH.
- **ALU_WB:** `result_src`=00, `reg_write`=1, `instr_done` -> FETCH.
- **BRANCH:** a=rs1, b=rs2, op 011, `result_src`=00.
  - taken = `zero` ^ (`funct3[0]` ^ `funct3[2]`); `pc_write`=taken.
  - `instr_done` -> FETCH.
  - funct3 010/011 -> TRAP, no writes.
- **JALR_ADD:** a=rs1, b=imm, add -> JALR_MASK.
- **JALR_MASK:** a=ALUOut, b=0xFFFF_FFFE, op 100 -> JUMP.
- **JUMP:** `result_src`=00, `pc_write`=1; a=OldPC, b=4, add (link into ALUOut) -> ALU_WB.
- **TRAP:** `illegal`=1, all enables 0, self-loop until reset.

## Timing
- **Reset:** while `rst_n`=0, every output is forced 0 combinationally (including `mem_req`), state=FETCH and `illegal`=0. First request on the first rising edge after release.
- **Reset mid-operation:** any outstanding request is abandoned (`mem_req` drops asynchronously); the memory must tolerate this.
- **Output decoding:** outputs are decoded from state. FETCH write enables are additionally gated by `mem_ready`; BRANCH `pc_write` by `zero`/`funct3`.
- **Handshake:** `mem_req`, `mem_we` and `addr_src` stay stable until `mem_ready`. `mem_ready` is ignored outside FETCH, MEM_RD and MEM_WR. A same-cycle `mem_ready` completes in one cycle.
- **Cycles per instruction** (zero-wait memory), +n per memory phase for n wait cycles:
  - FENCE 2; AUIPC 3; BRANCH 3.
  - R/I/LUI 4; store 4; JAL 4.
  - load 5; JALR 6.
- **`instr_done`:** exactly one pulse per retired instruction, never in TRAP.

## Test plan
- Reset mid-FETCH with `mem_ready` held 0 -> `mem_req` drops immediately. After release, FETCH `mem_req`=1 on the first cycle with `addr_src`=0; no writes before `mem_ready`.
- `add` (0110011), zero-wait -> states FETCH, DECODE, EXEC_R, ALU_WB. `alu_op`=010 in EXEC_R. `reg_write` only in cycle 4. `instr_done` pulses once.
- Load with 3 wait cycles in MEM_RD -> `mem_req`/`addr_src`=1 held 4 cycles, then MEM_WB with `result_src`=01. Total 8 cycles.
- BEQ and BNE, each with `zero`=1 and `zero`=0 -> `pc_write`=1 only for BEQ/`zero`=1 and BNE/`zero`=0. BGEU with `zero`=1 -> taken. funct3=010 -> `illegal`=1, sticky.
- JALR -> JALR_MASK drives `alu_op`=100 with b select 11. JUMP asserts `pc_write` with `result_src`=00. ALU_WB writes rd. Total 6 cycles.
- Opcode 1110011 -> TRAP: `illegal` stays 1, `mem_req`=0 forever, no `instr_done`. With `ENABLE_FENCE`=0, FENCE also traps.
